axis_pkt_rx: RTL and testbench
==============================

AXIS_PKT_RX -- requirements
Module: axis_pkt_rx

Interface
- REQ-001: Parameter DATA_WIDTH_BYTES, default 8: stream width in bytes; data width is 8*DATA_WIDTH_BYTES.
- REQ-002: Parameter MAX_PKT_BYTES, default 1518: largest legal packet in bytes; legal range 1..65534.
- REQ-003: clk  input  1  single clock; all logic samples on its rising edge.
- REQ-004: rst  input  1  reset, synchronous and active-high.
- REQ-005: s_axis  axi_stream_if.receiver  --  inbound stream (valid, data, last, keep in; ready out).
- REQ-006: desc_valid  output  1  a completed-packet descriptor is presented.
- REQ-007: desc_ready  input  1  the consumer accepts the descriptor.
- REQ-008: desc_len  output  16  packet byte count, saturating.
- REQ-009: desc_beats  output  12  packet beat count, saturating.
- REQ-010: desc_err_oversize  output  1  packet exceeded MAX_PKT_BYTES.
- REQ-011: desc_err_keep  output  1  illegal keep pattern seen in the packet.
- REQ-012: pkt_count  output  32  descriptors accepted since reset, wrapping.

Function
- REQ-013: The FSM SHALL have two states: RECV and HOLD.
- REQ-014: s_axis.ready SHALL be 1 exactly when state is RECV; it is registered, with no combinational path from desc_ready.
- REQ-015: A beat is accepted on a cycle where valid and ready are both 1; data is discarded and only keep and last are used.
- REQ-016: For each accepted beat, the byte accumulator SHALL add popcount(keep) (0..DATA_WIDTH_BYTES), saturating at 16'hFFFF.
- REQ-017: For each accepted beat, the beat accumulator SHALL add 1, saturating at 12'hFFF.
- REQ-018: The sticky oversize flag SHALL set when the updated byte count exceeds MAX_PKT_BYTES; the remaining beats are still accepted until last.
- REQ-019: On an accepted beat with last=1, the FSM SHALL go RECV->HOLD.
- REQ-020: On that same edge, the descriptor registers SHALL load the final counts including that beat, desc_valid SHALL go to 1, and the accumulators and flags SHALL clear.
- REQ-021: In HOLD, ready=0, and the descriptor outputs SHALL stay stable until desc_valid && desc_ready.
- REQ-022: On the desc_valid && desc_ready edge, the FSM SHALL go HOLD->RECV, desc_valid SHALL go to 0, and pkt_count SHALL increment.
- REQ-023: The minimum per-packet overhead is therefore one bubble cycle with ready=0.
- REQ-024: desc_ready while desc_valid=0 SHALL be ignored.
- REQ-025: pkt_count SHALL wrap from 32'hFFFFFFFF to 0.
- REQ-026: A beat with keep=0 and last=1 SHALL close the packet with 0 added bytes.

Reset
- REQ-027: When rst=1, at the next rising edge: state=RECV, ready=0 during the rst cycle then 1, desc_valid=0, desc_len=0, desc_beats=0, both error flags=0, pkt_count=0, accumulators=0.
- REQ-028: Reset mid-packet or in HOLD SHALL discard the partial packet or the pending descriptor, with no descriptor emitted.

Configuration
- REQ-029: The macro is AXIS_PKT_RX_KEEP_CHECK_EN.
- REQ-030: When AXIS_PKT_RX_KEEP_CHECK_EN is defined, desc_err_keep SHALL set sticky if a non-last beat has keep other than all ones.
- REQ-031: When AXIS_PKT_RX_KEEP_CHECK_EN is defined, desc_err_keep SHALL also set sticky if a last beat's keep is not of the form 2^n-1 (n=0..DATA_WIDTH_BYTES).
- REQ-032: When AXIS_PKT_RX_KEEP_CHECK_EN is undefined, desc_err_keep SHALL be tied 0, no check logic is present, and length counting is unchanged.

Structure
- REQ-033: Package axis_pkt_pkg SHALL hold the state enum (RECV, HOLD), LEN_W=16, BEATS_W=12, CNT_W=32, and the descriptor struct (len, beats, err_oversize, err_keep).
- REQ-034: Sub-module axis_keep_popcount SHALL be purely combinational: keep -> byte count plus the contiguity flag.

Verification (DATA_WIDTH_BYTES=8, MAX_PKT_BYTES=1518)
- REQ-035: 3 beats, keep FF/FF/0F, last on beat 3, desc_ready=1 -> desc_len=20, beats=3, no errors, ready=0 for exactly 1 cycle, pkt_count=1.
- REQ-036: 191 full beats -> desc_len=1528, err_oversize=1, all 191 beats accepted.
- REQ-037: Macro defined, keep 0F on a non-last beat -> err_keep=1; macro undefined, same stimulus -> err_keep=0 and desc_len unchanged.
- REQ-038: desc_ready held 0 for 10 cycles after a single-beat packet -> ready=0 and descriptor stable throughout; resumes 1 cycle after the handshake.
- REQ-039: rst pulsed mid-packet (beat 2 of 4) -> no descriptor emitted, pkt_count=0, the next packet is counted from 0.
- REQ-040: pkt_count preloaded to 32'hFFFFFFFF via force, one packet -> pkt_count=0.

Source files
------------

// File: rtl/axis_pkt_pkg.sv
// Shared types and widths for the packet-receive descriptor path.
package axis_pkt_pkg;

  localparam int LEN_W   = 16;
  localparam int BEATS_W = 12;
  localparam int CNT_W   = 32;

  typedef enum logic [0:0] {
    RECV = 1'b0,
    HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [BEATS_W-1:0] beats;
    logic               err_oversize;
    logic               err_keep;
  } desc_t;

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream bundle (valid/ready/data/keep/last).
interface axi_stream_if #(
  parameter int DATA_WIDTH_BYTES = 8
) ();
  logic                          valid;
  logic                          ready;
  logic [8*DATA_WIDTH_BYTES-1:0] data;
  logic [DATA_WIDTH_BYTES-1:0]   keep;
  logic                          last;

  modport receiver (input valid, input data, input keep, input last, output ready);
  modport sender   (output valid, output data, output keep, output last, input ready);
endinterface

// File: rtl/axis_keep_popcount.sv
// Combinational keep decode: number of set bytes, and whether keep is a
// low-aligned run of ones (2^n-1, including all-zero and all-ones).
module axis_keep_popcount #(
  parameter int KEEP_W = 8,
  parameter int CNT_W  = $clog2(KEEP_W + 1)
) (
  input  logic [KEEP_W-1:0] keep,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic              contig
);

  logic [KEEP_W-1:0] keep_inc;

  // Count set keep bits.
  always_comb begin
    byte_cnt = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      byte_cnt = byte_cnt + CNT_W'(keep[i]);
    end
  end

  // A run of ones from bit 0 has no bit in common with itself plus one.
  assign keep_inc = keep + KEEP_W'(1);
  assign contig   = ((keep & keep_inc) == '0);

endmodule

// File: rtl/axis_pkt_rx.sv
// Packet receiver: counts bytes/beats of each inbound packet and hands a
// descriptor to a consumer. Optional keep-pattern checking is enabled with
// the macro AXIS_PKT_RX_KEEP_CHECK_EN.
//
// state | meaning
// RECV  | accepting beats (ready=1), accumulating the current packet
// HOLD  | descriptor presented, stream stalled until desc_ready
module axis_pkt_rx
  import axis_pkt_pkg::*;
#(
  parameter int DATA_WIDTH_BYTES = 8,
  parameter int MAX_PKT_BYTES    = 1518
) (
  input  logic               clk,
  input  logic               rst,
  axi_stream_if.receiver     s_axis,
  output logic               desc_valid,
  input  logic               desc_ready,
  output logic [LEN_W-1:0]   desc_len,
  output logic [BEATS_W-1:0] desc_beats,
  output logic               desc_err_oversize,
  output logic               desc_err_keep,
  output logic [CNT_W-1:0]   pkt_count
);

  localparam int             CNT_BITS = $clog2(DATA_WIDTH_BYTES + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_BYTES);
  localparam logic [0:0]     ST_RECV  = RECV;
  localparam logic [0:0]     ST_HOLD  = HOLD;

  logic [0:0]         state_q, state_d;
  logic               ready_q, ready_d;
  logic               desc_valid_q, desc_valid_d;
  desc_t              desc_q, desc_d;
  logic [LEN_W-1:0]   acc_len_q, acc_len_d;
  logic [BEATS_W-1:0] acc_beats_q, acc_beats_d;
  logic               acc_ov_q, acc_ov_d;
  logic               acc_ke_q, acc_ke_d;
  logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;

  logic [CNT_BITS-1:0] keep_bytes;
  logic                keep_contig;
  logic                beat_acc;
  logic [LEN_W:0]      len_sum;
  logic [BEATS_W:0]    beat_sum;
  logic [LEN_W-1:0]    len_next;
  logic [BEATS_W-1:0]  beats_next;
  logic                ov_next;
  logic                ke_next;
  logic                unused_data;

  axis_keep_popcount #(
    .KEEP_W (DATA_WIDTH_BYTES),
    .CNT_W  (CNT_BITS)
  ) u_keep_popcount (
    .keep     (s_axis.keep),
    .byte_cnt (keep_bytes),
    .contig   (keep_contig)
  );

  // Payload bytes are never inspected, only keep/last.
  assign unused_data = ^s_axis.data;

  assign beat_acc   = s_axis.valid && ready_q;
  assign len_sum    = {1'b0, acc_len_q} + {{(LEN_W + 1 - CNT_BITS){1'b0}}, keep_bytes};
  assign beat_sum   = {1'b0, acc_beats_q} + {{BEATS_W{1'b0}}, 1'b1};
  assign len_next   = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
  assign beats_next = beat_sum[BEATS_W] ? '1 : beat_sum[BEATS_W-1:0];
  assign ov_next    = acc_ov_q || (len_next > MAX_LEN);

`ifdef AXIS_PKT_RX_KEEP_CHECK_EN
  // Mid-packet beats must be full; the closing beat must be low-aligned.
  assign ke_next = acc_ke_q ||
                   (s_axis.last ? !keep_contig : (s_axis.keep != '1));
`else
  logic unused_contig;
  assign unused_contig = keep_contig;
  assign ke_next       = 1'b0;
`endif

  // Next-state, accumulator and descriptor update.
  always_comb begin
    state_d      = state_q;
    desc_valid_d = desc_valid_q;
    desc_d       = desc_q;
    acc_len_d    = acc_len_q;
    acc_beats_d  = acc_beats_q;
    acc_ov_d     = acc_ov_q;
    acc_ke_d     = acc_ke_q;
    pkt_count_d  = pkt_count_q;
    case (state_q)
      ST_RECV: begin
        if (beat_acc) begin
          if (s_axis.last) begin
            state_d             = ST_HOLD;
            desc_valid_d        = 1'b1;
            desc_d.len          = len_next;
            desc_d.beats        = beats_next;
            desc_d.err_oversize = ov_next;
            desc_d.err_keep     = ke_next;
            acc_len_d           = '0;
            acc_beats_d         = '0;
            acc_ov_d            = 1'b0;
            acc_ke_d            = 1'b0;
          end else begin
            acc_len_d   = len_next;
            acc_beats_d = beats_next;
            acc_ov_d    = ov_next;
            acc_ke_d    = ke_next;
          end
        end
      end
      ST_HOLD: begin
        if (desc_valid_q && desc_ready) begin
          state_d      = ST_RECV;
          desc_valid_d = 1'b0;
          pkt_count_d  = pkt_count_q + CNT_W'(1);
        end
      end
      default: state_d = ST_RECV;
    endcase
    // ready is registered from the next state so desc_ready never reaches it combinationally.
    ready_d = (state_d == ST_RECV);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RECV;
      ready_q      <= 1'b0;
      desc_valid_q <= 1'b0;
      desc_q       <= '0;
      acc_len_q    <= '0;
      acc_beats_q  <= '0;
      acc_ov_q     <= 1'b0;
      acc_ke_q     <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      desc_valid_q <= desc_valid_d;
      desc_q       <= desc_d;
      acc_len_q    <= acc_len_d;
      acc_beats_q  <= acc_beats_d;
      acc_ov_q     <= acc_ov_d;
      acc_ke_q     <= acc_ke_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign s_axis.ready      = ready_q;
  assign desc_valid        = desc_valid_q;
  assign desc_len          = desc_q.len;
  assign desc_beats        = desc_q.beats;
  assign desc_err_oversize = desc_q.err_oversize;
  assign desc_err_keep     = desc_q.err_keep;
  assign pkt_count         = pkt_count_q;

endmodule

// File: tb/tb_axis_pkt_rx.sv
// Bench for axis_pkt_rx: randomized packets against a byte/beat reference
// model, scoreboard queue checked by an independent descriptor monitor.
module tb_axis_pkt_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        desc_valid;
  logic        desc_ready;
  logic [15:0] desc_len;
  logic [11:0] desc_beats;
  logic        desc_err_oversize;
  logic        desc_err_keep;
  logic [31:0] pkt_count;

  always #5 clk = ~clk;

  axi_stream_if #(.DATA_WIDTH_BYTES(8)) s_if ();

  axis_pkt_rx #(.DATA_WIDTH_BYTES(8), .MAX_PKT_BYTES(1518)) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis            (s_if),
    .desc_valid        (desc_valid),
    .desc_ready        (desc_ready),
    .desc_len          (desc_len),
    .desc_beats        (desc_beats),
    .desc_err_oversize (desc_err_oversize),
    .desc_err_keep     (desc_err_keep),
    .pkt_count         (pkt_count)
  );

  typedef struct {
    int len;
    int beats;
    bit ov;
    bit ke;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          rdy_mode = 0;
  logic [31:0] exp_cnt;

`ifdef AXIS_PKT_RX_KEEP_CHECK_EN
  localparam bit KCHK = 1'b1;
`else
  localparam bit KCHK = 1'b0;
`endif

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  // Reference: total bytes/beats with saturation, oversize, keep legality.
  function automatic exp_t model(input logic [7:0] k[$]);
    exp_t e;
    int   sum;
    int   n;
    bit   ke;
    bit   ok;
    sum = 0;
    ke  = 1'b0;
    n   = k.size();
    for (int i = 0; i < n; i++) begin
      sum += $countones(k[i]);
      if (i < n - 1) begin
        if (k[i] != 8'hFF) ke = 1'b1;
      end else begin
        ok = 1'b0;
        for (int m = 0; m <= 8; m++) if (int'(k[i]) == (1 << m) - 1) ok = 1'b1;
        if (!ok) ke = 1'b1;
      end
    end
    e.len   = (sum > 65535) ? 65535 : sum;
    e.beats = (n > 4095) ? 4095 : n;
    e.ov    = (sum > 1518);
    e.ke    = KCHK && ke;
    return e;
  endfunction

  // Consumer ready pattern, changed just after the rising edge.
  initial begin
    desc_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       desc_ready = 1'b1;
        1:       desc_ready = (($urandom % 3) != 0);
        default: desc_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every presented descriptor must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && desc_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL desc_unexpected actual=len%0d required=none", desc_len);
      end else begin
        chk("desc_len", desc_len, exp_q[0].len);
        chk("desc_beats", desc_beats, exp_q[0].beats);
        chk("desc_err_oversize", desc_err_oversize, exp_q[0].ov);
        chk("desc_err_keep", desc_err_keep, exp_q[0].ke);
        if (desc_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Drive one packet; returns on the falling edge after the last beat's edge.
  task automatic send_pkt(input logic [7:0] k[$]);
    int n;
    exp_q.push_back(model(k));
    exp_cnt++;
    for (int i = 0; i < k.size(); i++) begin
      @(negedge clk);
      s_if.valid = 1'b1;
      s_if.keep  = k[i];
      s_if.last  = (i == k.size() - 1);
      s_if.data  = {$urandom, $urandom};
      n = 0;
      while (!s_if.ready && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (n >= 400) fail_now("beat_wait");
      @(posedge clk);
    end
    @(negedge clk);
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    s_if.keep  = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_now("drain");
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] kq[$];
    int         n;
    rst        = 1'b1;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    s_if.keep  = '0;
    s_if.data  = '0;
    exp_cnt    = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", s_if.ready, 0);
    chk("rst_desc_valid", desc_valid, 0);
    chk("rst_desc_len", desc_len, 0);
    chk("rst_desc_beats", desc_beats, 0);
    chk("rst_err_ov", desc_err_oversize, 0);
    chk("rst_err_keep", desc_err_keep, 0);
    chk("rst_pkt_count", pkt_count, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", s_if.ready, 1);

    // Three beats FF/FF/0F, one bubble cycle
    kq = '{8'hFF, 8'hFF, 8'h0F};
    send_pkt(kq);
    chk("p3_bubble_ready", s_if.ready, 0);
    chk("p3_desc_valid", desc_valid, 1);
    chk("p3_len20", desc_len, 20);
    chk("p3_beats3", desc_beats, 3);
    @(negedge clk);
    chk("p3_ready_back", s_if.ready, 1);
    chk("p3_valid_clear", desc_valid, 0);
    chk("p3_pkt_count", pkt_count, exp_cnt);

    // Oversize: 191 full beats
    kq.delete();
    repeat (191) kq.push_back(8'hFF);
    send_pkt(kq);
    chk("ovs_len1528", desc_len, 1528);
    chk("ovs_beats191", desc_beats, 191);
    chk("ovs_flag", desc_err_oversize, 1);
    drain();

    // Partial keep on a non-last beat
    kq = '{8'h0F, 8'hFF};
    send_pkt(kq);
    chk("kchk_len12", desc_len, 12);
    chk("kchk_flag", desc_err_keep, KCHK);
    drain();

    // Zero-keep closing beat adds no bytes
    kq = '{8'hFF, 8'h00};
    send_pkt(kq);
    chk("k0_len8", desc_len, 8);
    chk("k0_beats2", desc_beats, 2);
    drain();

    // Consumer stalls 10 cycles after a single-beat packet
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    kq = '{8'h07};
    send_pkt(kq);
    for (int i = 0; i < 10; i++) begin
      chk("stall_ready", s_if.ready, 0);
      chk("stall_valid", desc_valid, 1);
      chk("stall_len", desc_len, 3);
      @(negedge clk);
    end
    rdy_mode = 0;
    n = 0;
    while (desc_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail_now("stall_release");
    chk("stall_ready_back", s_if.ready, 1);
    chk("stall_pkt_count", pkt_count, exp_cnt);

    // Reset while a descriptor is pending
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    kq = '{8'hFF};
    send_pkt(kq);
    chk("hold_rst_pre", desc_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    exp_cnt = '0;
    rdy_mode = 0;
    chk("hold_rst_valid", desc_valid, 0);
    chk("hold_rst_count", pkt_count, 0);

    // Reset during beat 2 of 4
    n = 0;
    while (!s_if.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    s_if.valid = 1'b1;
    s_if.keep  = 8'hFF;
    s_if.last  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_if.valid = 1'b0;
    s_if.keep  = '0;
    chk("mid_rst_valid", desc_valid, 0);
    chk("mid_rst_count", pkt_count, 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_valid_later", desc_valid, 0);
    kq = '{8'hFF, 8'hFF, 8'h03};
    send_pkt(kq);
    chk("mid_rst_next_len", desc_len, 18);
    chk("mid_rst_next_beats", desc_beats, 3);
    drain();
    chk("mid_rst_next_count", pkt_count, 1);

    // Randomized packets with random consumer backpressure
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, 20);
      kq.delete();
      for (int i = 0; i < n; i++) begin
        if (i < n - 1) kq.push_back((($urandom % 8) != 0) ? 8'hFF : 8'($urandom));
        else if (($urandom % 4) != 0) kq.push_back(8'((1 << $urandom_range(0, 8)) - 1));
        else kq.push_back(8'($urandom));
      end
      send_pkt(kq);
    end
    drain();
    rdy_mode = 0;
    chk("rand_pkt_count", pkt_count, exp_cnt);

    // Saturation of both counters
    kq.delete();
    repeat (8200) kq.push_back(8'hFF);
    send_pkt(kq);
    chk("sat_len", desc_len, 16'hFFFF);
    chk("sat_beats", desc_beats, 12'hFFF);
    chk("sat_ov", desc_err_oversize, 1);
    drain();

    // pkt_count wrap
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.pkt_count_q;
    exp_cnt = 32'hFFFF_FFFF;
    kq = '{8'h01};
    send_pkt(kq);
    drain();
    chk("wrap_count", pkt_count, exp_cnt);
    chk("wrap_zero", pkt_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
